// File: rtl/drive_sequencer.sv
// drive_sequencer: motor drive sequencer. Ramps the PWM duty toward a
// commanded target, inserts a coast interval before any direction reversal,
// and handles overcurrent faults with a cooldown/retry scheme that escalates
// to a latched lockout after repeated faults.
module drive_sequencer #(
  parameter int DUTY_W    = 8,
  parameter int RAMP_DIV  = 256,
  parameter int DEAD_CYC  = 1000,
  parameter int COOL_CYC  = 50000,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              over_i,
  input  logic              clear_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              dir_o,
  output logic              drive_en_o,
  output logic [2:0]        state_o,
  output logic [1:0]        fault_cnt_o,
  output logic              lockout_o
);

  localparam int RAMP_W = $clog2(RAMP_DIV + 1);
  localparam int DEAD_W = $clog2(DEAD_CYC + 1);
  localparam int COOL_W = $clog2(COOL_CYC + 1);

  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOL_CYC - 1);
  localparam logic [1:0]        RETRY_LIM = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_BRAKE   = 3'd2,
    ST_COOL    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  logic              over_meta_q;
  logic              over_s_q;
  logic [DUTY_W-1:0] tgt_duty_q;
  logic              tgt_dir_q;
  state_t            state_q;
  logic [DUTY_W-1:0] duty_q;
  logic              dir_q;
  logic              drive_en_q;
  logic [1:0]        fault_cnt_q;
  logic              lockout_q;
  logic [RAMP_W-1:0] ramp_cnt_q;
  logic [DEAD_W-1:0] dead_cnt_q;
  logic [COOL_W-1:0] cool_cnt_q;
  logic [COOL_W-1:0] clean_cnt_q;

  logic [DUTY_W-1:0] goal_duty;
  logic [DUTY_W-1:0] duty_step_d;
  logic [1:0]        fault_cnt_d;
  logic              fault_hit;
  logic              clear_ok;

  // Two-flop synchronizer for the asynchronous overcurrent comparator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      over_meta_q <= 1'b0;
      over_s_q    <= 1'b0;
    end else begin
      over_meta_q <= over_i;
      over_s_q    <= over_meta_q;
    end
  end

  // Next ramp value, saturating fault increment and fault/clear qualifiers.
  always_comb begin
    // A pending reversal ramps toward zero before the direction may change.
    goal_duty   = (tgt_dir_q != dir_q) ? '0 : tgt_duty_q;
    duty_step_d = duty_q;
    if (duty_q < goal_duty) begin
      duty_step_d = duty_q + DUTY_W'(1);
    end else if (duty_q > goal_duty) begin
      duty_step_d = duty_q - DUTY_W'(1);
    end
    fault_cnt_d = (fault_cnt_q == 2'd3) ? 2'd3 : fault_cnt_q + 2'd1;
    fault_hit   = over_s_q && ((state_q == ST_RUN) || (state_q == ST_BRAKE));
    clear_ok    = clear_i && !over_s_q;
  end

  // Target registers: commands load outside LOCKOUT; a lockout clear zeroes the duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_duty_q <= '0;
      tgt_dir_q  <= 1'b0;
    end else if (state_q == ST_LOCKOUT) begin
      if (clear_ok) begin
        tgt_duty_q <= '0;
      end
    end else if (cmd_valid) begin
      tgt_duty_q <= cmd_duty;
      tgt_dir_q  <= cmd_dir;
    end
  end

  // Sequencer FSM with registered duty, direction, enable and fault outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      duty_q      <= '0;
      dir_q       <= 1'b0;
      drive_en_q  <= 1'b0;
      fault_cnt_q <= 2'd0;
      lockout_q   <= 1'b0;
      ramp_cnt_q  <= '0;
      dead_cnt_q  <= '0;
      cool_cnt_q  <= '0;
      clean_cnt_q <= '0;
    end else begin
      // The clean-run window only accumulates while settled in RUN.
      clean_cnt_q <= '0;
      if (fault_hit) begin
        // Fault wins over any ramp step or transition in the same cycle.
        duty_q      <= '0;
        drive_en_q  <= 1'b0;
        fault_cnt_q <= fault_cnt_d;
        cool_cnt_q  <= '0;
        if (fault_cnt_d >= RETRY_LIM) begin
          state_q   <= ST_LOCKOUT;
          lockout_q <= 1'b1;
        end else begin
          state_q <= ST_COOL;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            duty_q     <= '0;
            drive_en_q <= 1'b0;
            if (tgt_duty_q != '0) begin
              state_q    <= ST_RUN;
              dir_q      <= tgt_dir_q;
              drive_en_q <= 1'b1;
              ramp_cnt_q <= '0;
            end
          end
          ST_RUN: begin
            if (ramp_cnt_q == RAMP_LAST) begin
              ramp_cnt_q <= '0;
              duty_q     <= duty_step_d;
            end else begin
              ramp_cnt_q <= ramp_cnt_q + RAMP_W'(1);
            end
            if (duty_q == tgt_duty_q) begin
              if (clean_cnt_q == COOL_LAST) begin
                fault_cnt_q <= 2'd0;
                clean_cnt_q <= '0;
              end else begin
                clean_cnt_q <= clean_cnt_q + COOL_W'(1);
              end
            end
            if ((tgt_dir_q != dir_q) && (duty_q == '0)) begin
              state_q    <= ST_BRAKE;
              drive_en_q <= 1'b0;
              dead_cnt_q <= '0;
            end else if ((duty_q == '0) && (tgt_duty_q == '0)) begin
              state_q    <= ST_IDLE;
              drive_en_q <= 1'b0;
            end
          end
          ST_BRAKE: begin
            duty_q     <= '0;
            drive_en_q <= 1'b0;
            if (dead_cnt_q == DEAD_LAST) begin
              dir_q      <= tgt_dir_q;
              ramp_cnt_q <= '0;
              if (tgt_duty_q != '0) begin
                state_q    <= ST_RUN;
                drive_en_q <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              dead_cnt_q <= dead_cnt_q + DEAD_W'(1);
            end
          end
          ST_COOL: begin
            duty_q     <= '0;
            drive_en_q <= 1'b0;
            if (over_s_q) begin
              cool_cnt_q <= '0;
            end else if (cool_cnt_q == COOL_LAST) begin
              dir_q      <= tgt_dir_q;
              ramp_cnt_q <= '0;
              if (tgt_duty_q != '0) begin
                state_q    <= ST_RUN;
                drive_en_q <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              cool_cnt_q <= cool_cnt_q + COOL_W'(1);
            end
          end
          ST_LOCKOUT: begin
            duty_q     <= '0;
            drive_en_q <= 1'b0;
            if (clear_ok) begin
              state_q     <= ST_IDLE;
              fault_cnt_q <= 2'd0;
              lockout_q   <= 1'b0;
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            duty_q     <= '0;
            drive_en_q <= 1'b0;
            lockout_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign duty_o      = duty_q;
  assign dir_o       = dir_q;
  assign drive_en_o  = drive_en_q;
  assign state_o     = state_q;
  assign fault_cnt_o = fault_cnt_q;
  assign lockout_o   = lockout_q;

endmodule

// File: doc/drive_sequencer.md
DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

Interface
REQ-001 Parameter DUTY_W, default 8: width of duty command and duty output.
REQ-002 Parameter RAMP_DIV, default 256: clock cycles per 1-LSB duty step.
REQ-003 Parameter DEAD_CYC, default 1000: coast cycles before a direction reversal.
REQ-004 Parameter COOL_CYC, default 50000: fault cooldown cycles; also the clean-run interval that clears the fault count.
REQ-005 Parameter MAX_RETRY, default 3: fault count that forces lockout (range 1..3).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 cmd_valid  in  1  single-cycle strobe; latches cmd_dir and cmd_duty.
REQ-009 cmd_dir  in  1  requested direction: 0 forward, 1 reverse.
REQ-010 cmd_duty  in  DUTY_W  requested duty target.
REQ-011 over_i  in  1  motor overcurrent comparator, active high, asynchronous to clk.
REQ-012 clear_i  in  1  lockout clear request, sampled on clk.
REQ-013 duty_o  out  DUTY_W  ramped duty to the PWM generator.
REQ-014 dir_o  out  1  applied direction.
REQ-015 drive_en_o  out  1  H-bridge drive enable; 0 forces motor outputs low.
REQ-016 state_o  out  3  encoding: IDLE=0, RUN=1, BRAKE=2, COOL=3, LOCKOUT=4.
REQ-017 fault_cnt_o  out  2  saturating overcurrent event count.
REQ-018 lockout_o  out  1  high only in LOCKOUT.

Function
REQ-019 over_i SHALL pass through a 2-flop synchronizer; over_s is the second-flop output, and all logic uses over_s only.
REQ-020 On cmd_valid in any state except LOCKOUT, the target registers SHALL load cmd_duty and cmd_dir at the next edge; cmd_valid SHALL be ignored in LOCKOUT.
REQ-021 IDLE: drive_en_o=0, duty_o=0; go to RUN when the target duty is nonzero, and set dir_o to the target direction on the same edge.
REQ-022 RUN: drive_en_o=1; every RAMP_DIV cycles, duty_o SHALL step 1 LSB toward the target duty, with no overshoot and no wrap.
REQ-023 RUN with target direction different from dir_o SHALL ramp duty_o down normally until it reaches 0, then enter BRAKE.
REQ-024 RUN with duty_o=0 and target duty=0 SHALL go to IDLE.
REQ-025 BRAKE: drive_en_o=0, duty_o=0; after exactly DEAD_CYC cycles, dir_o SHALL take the target direction and the state SHALL go to RUN, or to IDLE if the target duty is 0.
REQ-026 over_s=1 in RUN or BRAKE SHALL, at the next edge: set drive_en_o=0 and duty_o=0, increment fault_cnt_o (saturating at 3), and enter LOCKOUT if the new count >= MAX_RETRY, else COOL.
REQ-027 COOL: drive_en_o=0; the cooldown counter SHALL restart whenever over_s=1, and the state SHALL exit only after COOL_CYC consecutive cycles with over_s=0.
REQ-028 COOL exit SHALL go to RUN (ramping from 0) if the target duty is nonzero, else to IDLE; dir_o SHALL load the target direction on exit.
REQ-029 LOCKOUT: drive_en_o=0, duty_o=0; go to IDLE with fault_cnt_o=0 and target duty=0 only when clear_i=1 and over_s=0 in the same cycle.
REQ-030 In RUN, COOL_CYC consecutive fault-free cycles with duty_o equal to the target duty SHALL clear fault_cnt_o to 0.
REQ-031 Simultaneous over_s and cmd_valid: the fault transition takes priority, and the command is still latched.
REQ-032 A simultaneous duty step and fault SHALL yield duty_o=0.
REQ-033 Fault detection latency SHALL be at most 3 clk edges from the over_i rise to drive_en_o=0.
REQ-034 drive_en_o SHALL be 0 in every state except RUN.

Reset
REQ-035 rst_n=0 SHALL immediately and asynchronously force: state IDLE, duty_o=0, dir_o=0, drive_en_o=0, fault_cnt_o=0, lockout_o=0, target registers 0, all counters 0, synchronizer flops 0.
REQ-036 Reset asserted mid-ramp, mid-BRAKE, mid-COOL or in LOCKOUT SHALL give identical post-reset behaviour; release takes effect at the first clk edge after rst_n rises.

Verification
REQ-037 Ramp: RAMP_DIV=4; cmd_duty=10, dir 0 -> RUN; duty_o reaches 10 after 40 cycles ±1; drive_en_o=1.
REQ-038 Reversal: at duty 10, command dir 1, duty 10 -> ramp to 0, then BRAKE for DEAD_CYC cycles with drive_en_o=0, then dir_o=1 and ramp back to 10.
REQ-039 Retry: over_i pulsed high 5 cycles during RUN -> drive_en_o=0 within 3 edges, fault_cnt_o=1, COOL; after COOL_CYC quiet cycles, RUN resumes from 0.
REQ-040 Lockout: MAX_RETRY=3 with three faults -> LOCKOUT, lockout_o=1; clear_i while over_i=1 is ignored; clear_i with over_i=0 -> IDLE, fault_cnt_o=0.
REQ-041 Async reset: rst_n low mid-BRAKE with no clock -> all outputs at reset values before the next edge.
